// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl
//   EX-stage sequencer in front of the multi-cycle divider. Latches a DIV/DIVU
//   request, handshakes it into the divider, stalls the pipeline until the
//   result returns, then presents HI/LO write-back data for one cycle.
//   Divide-by-zero is answered locally with 0/0, a pipeline flush cancels the
//   divider, and a watchdog cancels a divider that never reports done.
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_div_req, i_signed     EX request (level, stable while stalled), DIV/DIVU
//   i_op_a, i_op_b          dividend / divisor
//   i_flush                 kill the current operation
//   i_pipe_hold             later stage stalling, EX instruction not advanced
//   o_div_start/_signed     start handshake and mode to divider
//   o_div_op0/_op1          operands to divider (0 outside the issue phase)
//   o_div_cancel            abort the divider (flush or watchdog)
//   i_div_ready             divider accepts start
//   i_div_done/_result      one-cycle result pulse, {remainder, quotient}
//   o_stall_req             freeze IF/ID/EX
//   o_hilo_we, o_hi, o_lo   HI/LO write-back
//   o_timeout               one-cycle watchdog error pulse
module div_issue_ctrl #(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 48
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_div_req,
  input  logic                  i_signed,
  input  logic [DATA_W-1:0]     i_op_a,
  input  logic [DATA_W-1:0]     i_op_b,
  input  logic                  i_flush,
  input  logic                  i_pipe_hold,
  output logic                  o_div_start,
  output logic                  o_div_signed,
  output logic [DATA_W-1:0]     o_div_op0,
  output logic [DATA_W-1:0]     o_div_op1,
  output logic                  o_div_cancel,
  input  logic                  i_div_ready,
  input  logic                  i_div_done,
  input  logic [2*DATA_W-1:0]   i_div_result,
  output logic                  o_stall_req,
  output logic                  o_hilo_we,
  output logic [DATA_W-1:0]     o_hi,
  output logic [DATA_W-1:0]     o_lo,
  output logic                  o_timeout
);

  typedef enum logic [2:0] {IDLE, ISSUE, BUSY, ZERO, DONE} state_t;

  localparam int               CNT_W   = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t              state;
  logic [DATA_W-1:0]   op_a;
  logic [DATA_W-1:0]   op_b;
  logic                op_signed;
  logic [DATA_W-1:0]   hi;
  logic [DATA_W-1:0]   lo;
  logic [CNT_W-1:0]    wd_cnt;
  logic                we_pend;   // set on DONE entry, cleared after its first cycle

  logic accept;
  logic in_flight;
  logic wd_expire;

  assign accept    = i_div_req && !i_flush;
  assign in_flight = (state == ISSUE) || (state == BUSY);
  // Flush and a same-cycle done both pre-empt the watchdog.
  assign wd_expire = (state == BUSY) && (wd_cnt == WD_LAST) && !i_div_done && !i_flush;

  assign o_div_start  = (state == ISSUE);
  assign o_div_signed = (state == ISSUE) && op_signed;
  assign o_div_op0    = (state == ISSUE) ? op_a : '0;
  assign o_div_op1    = (state == ISSUE) ? op_b : '0;
  assign o_div_cancel = (in_flight && i_flush) || wd_expire;
  assign o_timeout    = wd_expire;
  assign o_stall_req  = ((state == IDLE) && accept) || in_flight || (state == ZERO);
  assign o_hilo_we    = (state == DONE) && we_pend && !i_flush;
  assign o_hi         = hi;
  assign o_lo         = lo;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      op_a      <= '0;
      op_b      <= '0;
      op_signed <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      wd_cnt    <= '0;
      we_pend   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          we_pend <= 1'b0;
          if (accept) begin
            op_a      <= i_op_a;
            op_b      <= i_op_b;
            op_signed <= i_signed;
            state     <= (i_op_b == '0) ? ZERO : ISSUE;
          end
        end
        ISSUE: begin
          if (i_flush) begin
            state <= IDLE;
          end else if (i_div_ready) begin
            wd_cnt <= '0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (i_flush) begin
            state <= IDLE;
          end else if (i_div_done) begin
            hi      <= i_div_result[2*DATA_W-1:DATA_W];
            lo      <= i_div_result[DATA_W-1:0];
            we_pend <= 1'b1;
            state   <= DONE;
          end else if (wd_expire) begin
            hi      <= '0;
            lo      <= '0;
            we_pend <= 1'b1;
            state   <= DONE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        ZERO: begin
          hi <= '0;
          lo <= '0;
          if (i_flush) begin
            state <= IDLE;
          end else begin
            we_pend <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          // Holding here while the pipe is held keeps the same EX
          // instruction from being latched a second time.
          we_pend <= 1'b0;
          if (i_flush || !i_pipe_hold) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
module tb_div_issue_ctrl;

  localparam int DW = 32;
  localparam int TO = 48;

  logic            i_clk = 1'b0;
  logic            i_rst_n = 1'b0;
  logic            i_div_req = 1'b0;
  logic            i_signed = 1'b0;
  logic [DW-1:0]   i_op_a = '0;
  logic [DW-1:0]   i_op_b = '0;
  logic            i_flush = 1'b0;
  logic            i_pipe_hold = 1'b0;
  logic            o_div_start;
  logic            o_div_signed;
  logic [DW-1:0]   o_div_op0;
  logic [DW-1:0]   o_div_op1;
  logic            o_div_cancel;
  logic            i_div_ready = 1'b0;
  logic            i_div_done = 1'b0;
  logic [2*DW-1:0] i_div_result = '0;
  logic            o_stall_req;
  logic            o_hilo_we;
  logic [DW-1:0]   o_hi;
  logic [DW-1:0]   o_lo;
  logic            o_timeout;

  div_issue_ctrl #(.DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_div_req(i_div_req), .i_signed(i_signed),
    .i_op_a(i_op_a), .i_op_b(i_op_b), .i_flush(i_flush), .i_pipe_hold(i_pipe_hold),
    .o_div_start(o_div_start), .o_div_signed(o_div_signed), .o_div_op0(o_div_op0),
    .o_div_op1(o_div_op1), .o_div_cancel(o_div_cancel), .i_div_ready(i_div_ready),
    .i_div_done(i_div_done), .i_div_result(i_div_result), .o_stall_req(o_stall_req),
    .o_hilo_we(o_hilo_we), .o_hi(o_hi), .o_lo(o_lo), .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference quotient/remainder straight from the language operators.
  function automatic logic [2*DW-1:0] div_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic s);
    logic signed [DW-1:0] sa, sb;
    logic [DW-1:0] q, r;
    if (b == '0) return '0;
    if (s) begin
      sa = a; sb = b; q = sa / sb; r = sa % sb;
    end else begin
      q = a / b; r = a % b;
    end
    return {r, q};
  endfunction

  // ---------------- reference model (operation-level bookkeeping) ----------
  logic          m_wait, m_run, m_zero, m_wb, m_fresh, m_s;
  int            m_runcyc;
  logic [DW-1:0] m_a, m_b, m_hi, m_lo;

  task automatic model_reset();
    m_wait = 0; m_run = 0; m_zero = 0; m_wb = 0; m_fresh = 0; m_s = 0;
    m_runcyc = 0; m_a = '0; m_b = '0; m_hi = '0; m_lo = '0;
  endtask

  initial model_reset();

  // snapshots taken at the negedge, consumed at the following posedge
  logic s_rst = 0, s_req = 0, s_flush = 0, s_hold = 0, s_ready = 0, s_done = 0, s_sgn = 0;
  logic s_start = 0, s_cancel = 0, s_signed = 0, s_stall = 0;
  logic [DW-1:0] s_a = '0, s_b = '0, s_op0 = '0, s_op1 = '0;

  task automatic model_step();
    if (m_wait) begin
      if (s_flush) m_wait = 0;
      else if (s_ready) begin m_wait = 0; m_run = 1; m_runcyc = 0; end
    end else if (m_run) begin
      if (s_flush) m_run = 0;
      else if (s_done) begin
        {m_hi, m_lo} = div_ref(m_a, m_b, m_s);
        m_run = 0; m_wb = 1; m_fresh = 1;
      end else if (m_runcyc == TO - 1) begin
        m_hi = '0; m_lo = '0; m_run = 0; m_wb = 1; m_fresh = 1;
      end else m_runcyc++;
    end else if (m_zero) begin
      m_zero = 0; m_hi = '0; m_lo = '0;
      if (!s_flush) begin m_wb = 1; m_fresh = 1; end
    end else if (m_wb) begin
      m_fresh = 0;
      if (s_flush || !s_hold) m_wb = 0;
    end else if (s_req && !s_flush) begin
      m_a = s_a; m_b = s_b; m_s = s_sgn;
      if (s_b == '0) m_zero = 1; else m_wait = 1;
    end
  endtask

  // ---------------- divider model ----------------
  logic            rand_on = 0;
  int              dir_lat = 10;
  logic            dir_hang = 0, dir_late = 0;
  logic            d_busy = 0, d_hang = 0, d_late = 0;
  int              d_cnt = 0;
  logic [2*DW-1:0] d_res = '0;
  logic            nxt_done = 0, nxt_ready = 0;
  logic [2*DW-1:0] nxt_res = '0;

  task automatic div_step();
    nxt_done = 0;
    if (d_busy) begin
      if (s_cancel && (!d_late || d_hang)) d_busy = 0;
      else if (!d_hang) begin
        if (d_cnt == 0) begin nxt_done = 1; nxt_res = d_res; d_busy = 0; end
        else d_cnt--;
      end
    end else if (s_start && s_ready && !s_cancel) begin
      d_busy = 1;
      d_res  = div_ref(s_op0, s_op1, s_signed);
      if (rand_on) begin
        d_cnt  = $urandom_range(0, 50);
        d_hang = ($urandom_range(0, 15) == 0);
        d_late = 1'($urandom_range(0, 1));
      end else begin
        d_cnt = dir_lat; d_hang = dir_hang; d_late = dir_late;
      end
    end else if (rand_on && ($urandom_range(0, 15) == 0)) begin
      nxt_done = 1; nxt_res = {$urandom, $urandom};   // stray pulse, must be ignored
    end
    nxt_ready = !d_busy && (!rand_on || ($urandom_range(0, 3) != 0));
  endtask

  always @(posedge i_clk) begin
    if (!s_rst) begin
      model_reset();
      d_busy = 0; nxt_done = 0; nxt_ready = 0;
    end else begin
      model_step();
      div_step();
    end
    #1;
    i_div_ready  = nxt_ready;
    i_div_done   = nxt_done;
    i_div_result = nxt_res;
  end

  // ---------------- compare process ----------------
  logic e_idle, e_expire, e_cancel, e_stall, e_we;
  int   n_start = 0, n_we = 0, n_cancel = 0, n_timeout = 0, n_stall = 0;
  int   hs_cyc = -1, cancel_cyc = -1, tmo_cyc = -1;
  logic start_signed = 0;

  always @(negedge i_clk) begin
    cyc++;
    if (!i_rst_n) model_reset();
    e_idle   = !(m_wait || m_run || m_zero || m_wb);
    e_expire = m_run && (m_runcyc == TO - 1) && !i_div_done && !i_flush;
    e_cancel = ((m_wait || m_run) && i_flush) || e_expire;
    e_stall  = (e_idle && i_div_req && !i_flush) || m_wait || m_run || m_zero;
    e_we     = m_wb && m_fresh && !i_flush;
    chk("div_start",  o_div_start,  m_wait);
    chk("div_signed", o_div_signed, m_wait && m_s);
    chk("div_op0",    o_div_op0,    m_wait ? m_a : '0);
    chk("div_op1",    o_div_op1,    m_wait ? m_b : '0);
    chk("div_cancel", o_div_cancel, e_cancel);
    chk("timeout",    o_timeout,    e_expire);
    chk("stall_req",  o_stall_req,  e_stall);
    chk("hilo_we",    o_hilo_we,    e_we);
    chk("hi",         o_hi,         m_hi);
    chk("lo",         o_lo,         m_lo);

    if (o_div_start) begin n_start++; start_signed = o_div_signed; end
    if (o_div_start && i_div_ready) hs_cyc = cyc;
    if (o_div_cancel) begin n_cancel++; cancel_cyc = cyc; end
    if (o_timeout) begin n_timeout++; tmo_cyc = cyc; end
    if (o_hilo_we) n_we++;
    if (o_stall_req) n_stall++;

    s_rst = i_rst_n; s_req = i_div_req; s_flush = i_flush; s_hold = i_pipe_hold;
    s_ready = i_div_ready; s_done = i_div_done; s_sgn = i_signed; s_a = i_op_a; s_b = i_op_b;
    s_start = o_div_start; s_cancel = o_div_cancel; s_signed = o_div_signed;
    s_op0 = o_div_op0; s_op1 = o_div_op1; s_stall = o_stall_req;
  end

  // ---------------- stimulus ----------------
  task automatic clear_counts();
    n_start = 0; n_we = 0; n_cancel = 0; n_timeout = 0; n_stall = 0;
    hs_cyc = -1; cancel_cyc = -1; tmo_cyc = -1; start_signed = 0;
  endtask

  task automatic do_op(input logic sgn, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input int hold_n, output logic got, output logic [DW-1:0] hi_v,
                       output logic [DW-1:0] lo_v, output int req_c, output int we_c);
    @(posedge i_clk); #1;
    i_div_req = 1; i_signed = sgn; i_op_a = a; i_op_b = b;
    i_pipe_hold = (hold_n > 0); i_flush = 0;
    clear_counts();
    req_c = cyc + 1; got = 0; hi_v = '0; lo_v = '0; we_c = -1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge i_clk); #1;
      if (o_hilo_we) begin got = 1; hi_v = o_hi; lo_v = o_lo; we_c = cyc; end
    end
    chk("writeback_seen", got, 1'b1);
    if (hold_n > 0) begin
      repeat (hold_n) begin @(posedge i_clk); #1; end
      @(posedge i_clk); #1; i_pipe_hold = 0;
    end
    @(posedge i_clk); #1;
    i_div_req = 0; i_pipe_hold = 0;
    repeat (3) @(posedge i_clk);
    #1;
  endtask

  function automatic logic [DW-1:0] pick();
    case ($urandom_range(0, 3))
      0:       return DW'($urandom_range(0, 20));
      1:       return 32'hFFFF_FFFF - DW'($urandom_range(0, 19));
      default: return DW'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL sim_watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  logic [DW-1:0] hi_v, lo_v;
  logic          got;
  int            rc, wc, fl_cyc, cancel_before;

  initial begin
    // reset state
    repeat (2) @(negedge i_clk);
    #1;
    chk("rst_start", o_div_start, 1'b0);
    chk("rst_cancel", o_div_cancel, 1'b0);
    chk("rst_stall", o_stall_req, 1'b0);
    chk("rst_we", o_hilo_we, 1'b0);
    chk("rst_hi", o_hi, 32'h0);
    chk("rst_lo", o_lo, 32'h0);
    chk("rst_timeout", o_timeout, 1'b0);
    @(posedge i_clk); #1;
    i_rst_n = 1;
    repeat (2) @(posedge i_clk);

    // DIVU 100/7
    dir_lat = 31; dir_hang = 0; dir_late = 0;
    do_op(1'b0, 32'd100, 32'd7, 0, got, hi_v, lo_v, rc, wc);
    chk("divu_lo", lo_v, 32'd14);
    chk("divu_hi", hi_v, 32'd2);
    chk("divu_starts", n_start, 1);
    chk("divu_we_count", n_we, 1);
    chk("divu_latency", wc - rc, 35);
    chk("divu_stall_len", n_stall, wc - rc);

    // DIV -7/2
    dir_lat = 20;
    do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0, got, hi_v, lo_v, rc, wc);
    chk("div_lo", lo_v, 32'hFFFF_FFFD);
    chk("div_hi", hi_v, 32'hFFFF_FFFF);
    chk("div_signed_flag", start_signed, 1'b1);

    // DIV 5/0
    do_op(1'b1, 32'd5, 32'd0, 0, got, hi_v, lo_v, rc, wc);
    chk("zero_latency", wc - rc, 2);
    chk("zero_stall_len", n_stall, 2);
    chk("zero_starts", n_start, 0);
    chk("zero_hi", hi_v, 32'h0);
    chk("zero_lo", lo_v, 32'h0);

    // DIVU 9/3 flushed at BUSY cycle 10; the divider ignores cancel and reports late
    dir_lat = 40; dir_late = 1;
    @(posedge i_clk); #1;
    i_div_req = 1; i_signed = 0; i_op_a = 9; i_op_b = 3;
    clear_counts();
    for (int i = 0; i < 50 && hs_cyc < 0; i++) begin @(negedge i_clk); #1; end
    chk("flush_handshake_seen", hs_cyc >= 0, 1'b1);
    fl_cyc = hs_cyc + 10;
    repeat (10) @(posedge i_clk);
    #1; i_flush = 1;
    @(posedge i_clk); #1; i_flush = 0; i_div_req = 0;
    repeat (60) @(posedge i_clk);
    #1;
    chk("flush_cancel_count", n_cancel, 1);
    chk("flush_cancel_cycle", cancel_cyc, fl_cyc);
    chk("flush_no_we", n_we, 0);
    chk("flush_starts", n_start, 1);
    dir_late = 0;

    // DIVU 9/3 with pipe hold for 5 cycles after done
    dir_lat = 10;
    do_op(1'b0, 32'd9, 32'd3, 5, got, hi_v, lo_v, rc, wc);
    chk("hold_lo", lo_v, 32'd3);
    chk("hold_hi", hi_v, 32'd0);
    chk("hold_we_count", n_we, 1);
    chk("hold_starts", n_start, 1);

    // hung divider
    dir_hang = 1;
    do_op(1'b0, 32'd50, 32'd5, 0, got, hi_v, lo_v, rc, wc);
    dir_hang = 0;
    chk("wd_lo", lo_v, 32'd0);
    chk("wd_hi", hi_v, 32'd0);
    chk("wd_timeout_count", n_timeout, 1);
    chk("wd_cancel_count", n_cancel, 1);
    chk("wd_busy_cycle", tmo_cyc - hs_cyc, 48);
    chk("wd_cancel_with_timeout", cancel_cyc, tmo_cyc);

    // done in the same cycle the watchdog would fire
    dir_lat = 46;
    do_op(1'b0, 32'd1000, 32'd10, 0, got, hi_v, lo_v, rc, wc);
    chk("race_timeout_count", n_timeout, 0);
    chk("race_lo", lo_v, 32'd100);
    chk("race_hi", hi_v, 32'd0);
    chk("race_wb_cycle", wc - hs_cyc, 49);

    // randomized traffic
    rand_on = 1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge i_clk); #1;
      i_flush     = ($urandom_range(0, 39) == 0);
      i_pipe_hold = ($urandom_range(0, 2) == 0);
      if (!((s_stall || s_hold) && !s_flush)) begin
        i_div_req = 1'($urandom_range(0, 1));
        i_signed  = 1'($urandom_range(0, 1));
        i_op_a    = pick();
        i_op_b    = ($urandom_range(0, 7) == 0) ? '0 : pick();
        if (i_signed && i_op_a == 32'h8000_0000 && i_op_b == 32'hFFFF_FFFF) i_op_b = 32'd1;
      end
    end
    rand_on = 0;
    @(posedge i_clk); #1;
    i_div_req = 0; i_flush = 0; i_pipe_hold = 0;
    for (int i = 0; i < 200 && (d_busy || m_wait || m_run || m_zero || m_wb); i++) begin
      @(negedge i_clk); #1;
    end
    chk("quiesce_stall", o_stall_req, 1'b0);

    // reset in the middle of a divide: abandoned without cancel
    dir_lat = 30;
    @(posedge i_clk); #1;
    i_div_req = 1; i_signed = 0; i_op_a = 77; i_op_b = 7;
    clear_counts();
    for (int i = 0; i < 50 && hs_cyc < 0; i++) begin @(negedge i_clk); #1; end
    chk("midrst_handshake_seen", hs_cyc >= 0, 1'b1);
    repeat (5) @(posedge i_clk);
    #1;
    cancel_before = n_cancel;
    i_rst_n = 0; i_div_req = 0;
    @(negedge i_clk); #1;
    chk("midrst_cancel", o_div_cancel, 1'b0);
    chk("midrst_stall", o_stall_req, 1'b0);
    @(posedge i_clk); #1;
    i_rst_n = 1;
    repeat (3) @(posedge i_clk);
    #1;
    chk("midrst_cancel_count", n_cancel, cancel_before);

    dir_lat = 5;
    do_op(1'b0, 32'd20, 32'd4, 0, got, hi_v, lo_v, rc, wc);
    chk("post_rst_lo", lo_v, 32'd5);
    chk("post_rst_hi", hi_v, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
